// File: rtl/accel_spi_pkg.sv
// Shared constants, state encodings and frame helpers for the accelerometer SPI reader.
package accel_spi_pkg;

    localparam int unsigned FRAME_BITS = 24;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;

    typedef enum logic [1:0] {
        StStartup,
        StInitXfer,
        StWait,
        StReadXfer
    } reader_state_e;

    typedef enum logic [2:0] {
        ShIdle,
        ShLead,
        ShHigh,
        ShLow,
        ShTrail,
        ShGap
    } shifter_state_e;

    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] b2,
                                                         input logic [7:0] b1,
                                                         input logic [7:0] b0);
        return {b2, b1, b0};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Mode-0 SPI frame engine: one 24-bit full-duplex frame per start, MSB first,
// with a guaranteed chip-select high gap of 2*Half cycles before the next frame.
module spi_frame_shifter
    import accel_spi_pkg::*;
#(
    parameter int unsigned Half = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] tx_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_no,
    output logic [FRAME_BITS-1:0] rx_o,
    output logic                  done_o,
    output logic                  ready_o
);

    localparam int unsigned CntW = $clog2(2 * Half + 1);
    localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

    shifter_state_e        state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  done_q, done_d;
    logic                  half_end;

    assign half_end = (cnt_q == CntW'(Half - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;

        unique case (state_q)
            ShIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_i[FRAME_BITS-1];
                    shift_d = {tx_i[FRAME_BITS-2:0], 1'b0};
                    bit_d   = '0;
                    rx_d    = '0;
                    state_d = ShLead;
                end
            end
            ShLead: begin
                if (half_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[FRAME_BITS-2:0], miso_i};
                    state_d = ShHigh;
                end
            end
            ShHigh: begin
                // Next bit goes out on the falling edge so it is settled long before the rise.
                if (half_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = shift_q[FRAME_BITS-1];
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    state_d = ShLow;
                end
            end
            ShLow: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (bit_q == BitW'(FRAME_BITS - 1)) begin
                        state_d = ShTrail;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[FRAME_BITS-2:0], miso_i};
                        bit_d   = bit_q + BitW'(1);
                        state_d = ShHigh;
                    end
                end
            end
            ShTrail: begin
                if (half_end) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ShGap;
                end
            end
            ShGap: begin
                if (cnt_q == CntW'(2 * Half - 1)) begin
                    cnt_d   = '0;
                    state_d = ShIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ShIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ShIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;
    assign cs_no   = cs_n_q;
    assign rx_o    = rx_q;
    assign done_o  = done_q;
    assign ready_o = (state_q == ShIdle);

endmodule

// File: rtl/accel_spi_reader.sv
// Accelerometer SPI poller: one-shot POWER_CTL write, then periodic single-register reads.
// ACCEL_OFFSET_EN converts each two's-complement sample to offset binary on DataOut.
module accel_spi_reader
    import accel_spi_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SCLK_HZ        = 1_000_000,
    parameter int unsigned STARTUP_CYCLES = 600_000,
    parameter int unsigned SAMPLE_CYCLES  = 1_000_000,
    parameter logic [7:0]  REG_ADDR       = 8'h08
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_n,
    output logic [7:0] DataOut,
    output logic       ValidData,
    output logic       Busy
);

    localparam int unsigned HALF = CLK_HZ / (2 * SCLK_HZ);
    localparam int unsigned StW  = $clog2(STARTUP_CYCLES + 1);
    localparam int unsigned SmpW = $clog2(SAMPLE_CYCLES + 1);

    if (HALF < 1) begin : g_half_check
        $error("accel_spi_reader: CLK_HZ/(2*SCLK_HZ) must be at least 1");
    end

    reader_state_e         state_q, state_d;
    logic [StW-1:0]        startup_cnt_q, startup_cnt_d;
    logic [SmpW-1:0]       sample_cnt_q, sample_cnt_d;
    logic                  sample_run_q, sample_run_d;
    logic                  pending_q, pending_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  tick;
    logic                  frame_start;
    logic [FRAME_BITS-1:0] frame_tx;
    logic [FRAME_BITS-1:0] frame_rx;
    logic                  frame_done;
    logic                  frame_ready;
    logic                  unused_rx;

    assign unused_rx = ^frame_rx[FRAME_BITS-1:8];
    assign tick      = sample_run_q && (sample_cnt_q == SmpW'(SAMPLE_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        startup_cnt_d = startup_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        sample_run_d  = sample_run_q;
        pending_d     = pending_q | tick;
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_start   = 1'b0;
        frame_tx      = '0;

        if (sample_run_q) begin
            sample_cnt_d = tick ? '0 : sample_cnt_q + SmpW'(1);
        end

        unique case (state_q)
            StStartup: begin
                if (startup_cnt_q == StW'(STARTUP_CYCLES - 1)) begin
                    startup_cnt_d = '0;
                    frame_start   = 1'b1;
                    frame_tx      = frame_word(CMD_WRITE, REG_POWER_CTL, PWR_MEASURE);
                    state_d       = StInitXfer;
                end else begin
                    startup_cnt_d = startup_cnt_q + StW'(1);
                end
            end
            StInitXfer: begin
                if (frame_done) begin
                    sample_run_d = 1'b1;
                    sample_cnt_d = '0;
                    pending_d    = 1'b0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                // Ticks seen during a read are merged into one pending request.
                if ((pending_q || tick) && frame_ready) begin
                    frame_start = 1'b1;
                    frame_tx    = frame_word(CMD_READ, REG_ADDR, 8'h00);
                    pending_d   = 1'b0;
                    state_d     = StReadXfer;
                end
            end
            StReadXfer: begin
                if (frame_done) begin
`ifdef ACCEL_OFFSET_EN
                    data_d = frame_rx[7:0] ^ 8'h80;
`else
                    data_d = frame_rx[7:0];
`endif
                    valid_d = 1'b1;
                    state_d = StWait;
                end
            end
            default: state_d = StStartup;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= StStartup;
            startup_cnt_q <= '0;
            sample_cnt_q  <= '0;
            sample_run_q  <= 1'b0;
            pending_q     <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            startup_cnt_q <= startup_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            sample_run_q  <= sample_run_d;
            pending_q     <= pending_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
        end
    end

    spi_frame_shifter #(
        .Half(HALF)
    ) u_shifter (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .start_i(frame_start),
        .tx_i   (frame_tx),
        .miso_i (MISO),
        .sclk_o (SCLK),
        .mosi_o (MOSI),
        .cs_no  (CS_n),
        .rx_o   (frame_rx),
        .done_o (frame_done),
        .ready_o(frame_ready)
    );

    assign DataOut   = data_q;
    assign ValidData = valid_q;
    assign Busy      = ~CS_n;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Scoreboard bench for accel_spi_reader: frame and sample expectations are queued by the
// stimulus and consumed by monitors; a second instance exercises back-to-back reads.
module tb_accel_spi_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       miso;
    logic       sclk, mosi, cs_n, valid, busy;
    logic [7:0] dout;

    logic       rst_f_n;
    logic       miso_f;
    logic       sclk_f, mosi_f, cs_f, valid_f, busy_f;
    logic [7:0] dout_f;

    always #5 clk = ~clk;

    accel_spi_reader #(
        .CLK_HZ        (100_000_000),
        .SCLK_HZ       (25_000_000),
        .STARTUP_CYCLES(20),
        .SAMPLE_CYCLES (400),
        .REG_ADDR      (8'h08)
    ) u_dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .MISO     (miso),
        .SCLK     (sclk),
        .MOSI     (mosi),
        .CS_n     (cs_n),
        .DataOut  (dout),
        .ValidData(valid),
        .Busy     (busy)
    );

    accel_spi_reader #(
        .CLK_HZ        (100_000_000),
        .SCLK_HZ       (25_000_000),
        .STARTUP_CYCLES(20),
        .SAMPLE_CYCLES (60),
        .REG_ADDR      (8'h08)
    ) u_fast (
        .Clk      (clk),
        .Rst_n    (rst_f_n),
        .MISO     (miso_f),
        .SCLK     (sclk_f),
        .MOSI     (mosi_f),
        .CS_n     (cs_f),
        .DataOut  (dout_f),
        .ValidData(valid_f),
        .Busy     (busy_f)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_frame_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  sensor_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual event/timeout, required none", name);
    endtask

    function automatic logic [7:0] fmt(input logic [7:0] s);
`ifdef ACCEL_OFFSET_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    // Sensor model: mode 0, first bit at CS_n fall, next bit after each SCLK fall.
    logic [23:0] sens_word;
    int          sens_idx;
    always @(negedge cs_n) begin
        sens_word = {16'hA5C3, 8'h00};
        if (sensor_q.size() > 0) sens_word[7:0] = sensor_q.pop_front();
        miso     = sens_word[23];
        sens_idx = 22;
    end
    always @(negedge sclk) begin
        if (!cs_n && sens_idx >= 0) begin
            miso = sens_word[sens_idx];
            sens_idx--;
        end
    end

    bit          in_frame = 1'b0;
    int          rises = 0, low_cyc = 0, m0_viol = 0, idle_viol = 0, hold_viol = 0;
    int          frames_done = 0, valid_cnt = 0, cyc = 0, cs_rise_cyc = 0, last_valid_cyc = -1;
    logic        sclk_p = 1'b0, mosi_p = 1'b0;
    logic [23:0] cap = '0;
    logic [7:0]  last_dout = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame       = 1'b0;
            rises          = 0;
            sclk_p         = 1'b0;
            mosi_p         = 1'b0;
            last_dout      = '0;
            last_valid_cyc = -1;
        end else begin
            if (cs_n && sclk) idle_viol++;
            if (!cs_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    rises    = 0;
                    low_cyc  = 0;
                    m0_viol  = 0;
                    cap      = '0;
                end
                low_cyc++;
                if (sclk && !sclk_p) begin
                    rises++;
                    cap = {cap[22:0], mosi};
                    if (mosi !== mosi_p) m0_viol++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                frames_done++;
                cs_rise_cyc = cyc;
                if (exp_frame_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    check("frame_mosi", cap, exp_frame_q.pop_front());
                    check("frame_rises", rises, 24);
                    check("cs_low_cycles", low_cyc, 100);
                    check("mode0_mosi_stable", m0_viol, 0);
                end
            end
            if (valid) begin
                if (exp_data_q.size() == 0) fail_now("unexpected_valid");
                else check("data_out", dout, exp_data_q.pop_front());
                check("valid_after_cs_rise", cyc - cs_rise_cyc, 1);
                if (last_valid_cyc >= 0) check("valid_spacing", cyc - last_valid_cyc, 400);
                last_valid_cyc = cyc;
                last_dout      = dout;
                valid_cnt++;
            end else if (dout !== last_dout) begin
                hold_viol++;
            end
            sclk_p = sclk;
            mosi_p = mosi;
        end
    end

    // Back-to-back monitor: gaps between read frames must be short but at least 2T.
    int   f_gap = 0, f_gaps = 0, f_gaps_checked = 0;
    logic f_csp = 1'b1;
    always @(negedge clk) begin
        if (rst_f_n) begin
            if (cs_f) begin
                f_gap++;
            end else begin
                if (f_csp) begin
                    f_gaps++;
                    if (f_gaps >= 3 && f_gaps_checked < 5) begin
                        f_gaps_checked++;
                        check("b2b_gap_min4", 32'(f_gap >= 4), 1);
                        check("b2b_gap_max6", 32'(f_gap <= 6), 1);
                    end
                end
                f_gap = 0;
            end
            f_csp = cs_f;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual time limit hit, required run end");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  fd;
        bit  hit;
        rst_n   = 1'b0;
        rst_f_n = 1'b0;
        miso    = 1'b0;
        miso_f  = 1'b0;

        sensor_q.push_back(8'hEE);
        exp_frame_q.push_back(24'h0A2D02);
        sensor_q.push_back(8'h5A);
        sensor_q.push_back(8'hB2);
        sensor_q.push_back(8'h7F);
        repeat (3) exp_frame_q.push_back(24'h0B0800);
        exp_data_q.push_back(fmt(8'h5A));
        exp_data_q.push_back(fmt(8'hB2));
        exp_data_q.push_back(fmt(8'h7F));

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_dataout", dout, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        @(negedge clk);
        rst_n   = 1'b1;
        rst_f_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!cs_n) break;
        end
        check("startup_cycles", n, 20);

        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid_cnt >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("timeout_three_reads");

        // Abort the next read at its tenth SCLK rise.
        sensor_q.push_back(8'h33);
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (in_frame && rises == 10) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("timeout_mid_read");
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);

        sensor_q.delete();
        sensor_q.push_back(8'hEE);
        exp_frame_q.push_back(24'h0A2D02);
        repeat (2) @(negedge clk);
        fd    = frames_done;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!cs_n) break;
        end
        check("restart_startup_cycles", n, 20);

        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (frames_done == fd + 1) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("timeout_reinit");
        repeat (20) @(negedge clk);

        check("no_valid_abort_or_init", valid_cnt, 3);
        check("sclk_idle_low", idle_viol, 0);
        check("dataout_hold", hold_viol, 0);
        check("frames_left", exp_frame_q.size(), 0);
        check("data_left", exp_data_q.size(), 0);
        check("b2b_gaps_seen", f_gaps_checked, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
